result_bcd: RTL and testbench
=============================

# result_bcd

Converts the 16-bit sign-magnitude result from `gencon` (`display_output`, qualified by `complete`) back into decimal form for the display path. It runs the reverse of the digit-entry path: binary result in, sign plus five BCD digits out. Digits are available in parallel and as a digit-serial stream with a valid/ready handshake, most-significant digit first. It sits between `gencon` and the display multiplexer.

## Interface
Parameters:
- `NDIG`, 5: number of BCD digits. Fixed at 5 for a 15-bit magnitude; other values are unsupported.

Ports:
- `clk` in 1: system clock.
- `nRST` in 1: asynchronous, active-low reset.
- `result_in` in 16: bit 15 is the sign; bits [14:0] are the magnitude (0..32767).
- `complete` in 1: level from `gencon`. Its rising edge requests a conversion.
- `busy` out 1: high while in CONV or STREAM.
- `bcd_valid` out 1: `bcd`/`sign` hold a finished conversion.
- `sign` out 1: result is negative. Forced to 0 when the magnitude is 0.
- `bcd` out 20: five BCD digits; [19:16] is the ten-thousands digit, [3:0] is the ones digit.
- `blank` out 5: leading-zero blank mask; bit i blanks digit i.
- `digit_valid` out 1: stream digit is presented.
- `digit_ready` in 1: consumer accepts the stream digit.
- `digit_data` out 4: BCD value of the stream digit.
- `digit_idx` out 3: position of the stream digit, 4 (MSD) down to 0.
- `done` out 1: one-cycle pulse after the last digit is accepted.

## Operation
- Edge detect: `complete_q` registers `complete`. A start is `complete & ~complete_q`. If `complete` is held high, only one start occurs.
- FSM states: IDLE, CONV, STREAM.
- IDLE:
  - On start: capture `result_in[14:0]` into the shift register.
  - Capture `sign_r = result_in[15] & (|result_in[14:0])`.
  - Clear the BCD accumulator and `bcd_valid`, set count = 15, go to CONV.
- CONV: double-dabble, one magnitude bit per cycle.
  - Add 3 to each accumulator nibble ≥5.
  - Then shift {acc, mag} left by 1 and decrement count.
  - After the 15th shift: latch `bcd`, `sign`, `blank`; set `bcd_valid`; go to STREAM.
- STREAM:
  - `digit_valid` = 1; `digit_data` = digit at `digit_idx`.
  - On `digit_valid & digit_ready`:
    - If idx = 0: pulse `done` and go to IDLE.
    - Otherwise decrement idx.
  - `digit_data` and `digit_idx` are stable while `digit_valid & ~digit_ready`.
- Start while `busy`: ignored. The edge is lost and is not queued.
- `bcd_valid` stays high in IDLE until the next start clears it.
- Accumulator width: 20 bits. The nibble adjust never overflows for inputs ≤32767.

## Timing
- Reset values: state IDLE; all outputs 0 (`busy`, `bcd_valid`, `sign`, `bcd`, `blank`, `digit_valid`, `digit_data`, `digit_idx`, `done`); `complete_q` = 0.
- Start detected at posedge N → CONV from N.
- Shifts occur at posedges N+1..N+15.
- `bcd_valid` and `digit_valid` are high after posedge N+15.
- Conversion latency is 15 cycles from the capture edge.
- With `digit_ready` tied high, the stream takes 5 cycles (fewer with blanking). `done` is high for the cycle after the final transfer edge, and `busy` falls on that same edge.
- Reset mid-CONV or mid-STREAM: immediate asynchronous return to reset values. No `done` is issued.
- A `complete` edge coincident with the final transfer edge is ignored, because the FSM is not yet in IDLE.

## Configuration
- `RESULT_BCD_LZB_EN` defined:
  - `blank[i]` = 1 for each leading zero digit above the first nonzero digit; `blank[0]` is never set.
  - STREAM starts at the highest non-blanked index, so leading zeros are skipped. A result of 0 streams only idx 0.
- `RESULT_BCD_LZB_EN` undefined:
  - `blank` is tied to 0.
  - STREAM always emits idx 4..0.

## Test plan
- `result_in` = 0x0022 (34), `complete` rises, ready high:
  - `bcd` = 0x00034, `sign` = 0, `bcd_valid` 15 cycles after capture.
  - Stream 0,0,0,3,4, or 3,4 with LZB; then `done`.
- `result_in` = 0x8028 (−40) → `sign` = 1, `bcd` = 0x00040; with LZB, `blank` = 5'b11100.
- `result_in` = 0x7FFF → `bcd` = 0x32767. Hold `digit_ready` low for 3 cycles at idx 2 → `digit_data` stays 7 and `digit_idx` stays 2 during the stall.
- `result_in` = 0x8000 (negative zero) → `sign` = 0, `bcd` = 0; stream ends with a single 0 at idx 0 (with LZB).
- Hold `complete` high for 40 cycles → exactly one conversion and one `done`. A second `complete` edge during CONV is ignored.
- Assert `nRST` low at cycle 7 of CONV → all outputs 0 immediately. A new `complete` edge after reset converts correctly.

Source files
------------

// File: rtl/result_bcd.sv
// result_bcd: converts a 16-bit sign-magnitude result into sign plus five BCD digits
// using a serial double-dabble, then streams the digits MSD first over valid/ready.
// Optional feature macro: RESULT_BCD_LZB_EN enables leading-zero blanking and skip.
module result_bcd #(
  parameter int unsigned NDIG = 5
) (
  input  logic                clk,
  input  logic                nRST,
  input  logic [15:0]         result_in,
  input  logic                complete,
  output logic                busy,
  output logic                bcd_valid,
  output logic                sign,
  output logic [4*NDIG-1:0]   bcd,
  output logic [NDIG-1:0]     blank,
  output logic                digit_valid,
  input  logic                digit_ready,
  output logic [3:0]          digit_data,
  output logic [2:0]          digit_idx,
  output logic                done
);

  typedef enum logic [1:0] {StIdle, StConv, StStream} state_e;

  state_e              state_q, state_d;
  logic                complete_q;
  logic [4*NDIG-1:0]   acc_q, acc_d;
  logic [14:0]         mag_q, mag_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                sign_r_q, sign_r_d;
  logic [4*NDIG-1:0]   bcd_q, bcd_d;
  logic                sign_q, sign_d;
  logic [NDIG-1:0]     blank_q, blank_d;
  logic                valid_q, valid_d;
  logic [2:0]          idx_q, idx_d;
  logic                done_q, done_d;

  logic                start;
  logic [4*NDIG-1:0]   acc_adj;
  logic [4*NDIG-1:0]   acc_sh;
  logic [14:0]         mag_sh;
  logic [NDIG-1:0]     blank_n;
  logic [2:0]          first_idx;

  assign start = complete & ~complete_q;

  // Double-dabble step: add 3 to every nibble >= 5, then shift {acc, mag} left by one.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < NDIG; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_sh = {acc_adj[4*NDIG-2:0], mag_q[14]};
    mag_sh = {mag_q[13:0], 1'b0};
  end

  // Blank mask and first stream index derived from the final shifted accumulator.
  always_comb begin
    blank_n   = '0;
    first_idx = 3'(NDIG - 1);
`ifdef RESULT_BCD_LZB_EN
    blank_n[NDIG-1] = (acc_sh[4*NDIG-1 -: 4] == 4'd0);
    for (int i = NDIG - 2; i >= 1; i--) begin
      blank_n[i] = blank_n[i+1] & (acc_sh[4*i +: 4] == 4'd0);
    end
    blank_n[0] = 1'b0;
    // Ascending scan: the last unblanked index found is the highest one.
    first_idx = 3'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (!blank_n[i]) first_idx = 3'(i);
    end
`endif
  end

  // FSM next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mag_d    = mag_q;
    cnt_d    = cnt_q;
    sign_r_d = sign_r_q;
    bcd_d    = bcd_q;
    sign_d   = sign_q;
    blank_d  = blank_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mag_d    = result_in[14:0];
          sign_r_d = result_in[15] & (|result_in[14:0]);
          acc_d    = '0;
          valid_d  = 1'b0;
          cnt_d    = 4'd15;
          state_d  = StConv;
        end
      end
      StConv: begin
        acc_d = acc_sh;
        mag_d = mag_sh;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          bcd_d   = acc_sh;
          sign_d  = sign_r_q;
          blank_d = blank_n;
          idx_d   = first_idx;
          valid_d = 1'b1;
          state_d = StStream;
        end
      end
      StStream: begin
        if (digit_ready) begin
          if (idx_q == 3'd0) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            idx_d = idx_q - 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q    <= StIdle;
      complete_q <= 1'b0;
      acc_q      <= '0;
      mag_q      <= '0;
      cnt_q      <= '0;
      sign_r_q   <= 1'b0;
      bcd_q      <= '0;
      sign_q     <= 1'b0;
      blank_q    <= '0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      complete_q <= complete;
      acc_q      <= acc_d;
      mag_q      <= mag_d;
      cnt_q      <= cnt_d;
      sign_r_q   <= sign_r_d;
      bcd_q      <= bcd_d;
      sign_q     <= sign_d;
      blank_q    <= blank_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
    end
  end

  // Stream digit select from the latched result.
  always_comb begin
    digit_data = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == 3'(i)) digit_data = bcd_q[4*i +: 4];
    end
  end

  assign busy        = (state_q != StIdle);
  assign digit_valid = (state_q == StStream);
  assign bcd_valid   = valid_q;
  assign sign        = sign_q;
  assign bcd         = bcd_q;
  assign blank       = blank_q;
  assign digit_idx   = idx_q;
  assign done        = done_q;

endmodule

// File: tb/tb_result_bcd.sv
// Testbench for result_bcd: randomized and directed conversions checked against a
// decimal-arithmetic model; follows RESULT_BCD_LZB_EN for blanking expectations.
module tb_result_bcd;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic [15:0] result_in = '0;
  logic        complete = 1'b0;
  logic        busy, bcd_valid, sign, digit_valid, done;
  logic [19:0] bcd;
  logic [4:0]  blank;
  logic        digit_ready = 1'b1;
  logic [3:0]  digit_data;
  logic [2:0]  digit_idx;

  int total = 0;
  int bad = 0;

  int          exp_d[5];
  int          exp_top;
  logic [19:0] exp_bcd;
  logic [4:0]  exp_blank;
  logic        exp_sign;

  result_bcd #(.NDIG(5)) dut (
    .clk(clk), .nRST(nRST), .result_in(result_in), .complete(complete),
    .busy(busy), .bcd_valid(bcd_valid), .sign(sign), .bcd(bcd), .blank(blank),
    .digit_valid(digit_valid), .digit_ready(digit_ready), .digit_data(digit_data),
    .digit_idx(digit_idx), .done(done)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Decimal model: digits by division, blanking from the first nonzero digit.
  task automatic model(input logic [15:0] v);
    int m;
    int p;
    m = int'(v[14:0]);
    p = 1;
    exp_bcd = '0;
    for (int i = 0; i < 5; i++) begin
      exp_d[i] = (m / p) % 10;
      exp_bcd[4*i +: 4] = 4'(exp_d[i]);
      p = p * 10;
    end
    exp_sign  = v[15] && (m != 0);
    exp_blank = '0;
`ifdef RESULT_BCD_LZB_EN
    exp_top = 0;
    for (int i = 0; i < 5; i++) if (exp_d[i] != 0) exp_top = i;
    for (int i = exp_top + 1; i < 5; i++) exp_blank[i] = 1'b1;
`else
    exp_top = 4;
`endif
  endtask

  task automatic check_all_zero(input string name);
    logic [36:0] obs;
    obs = {busy, bcd_valid, sign, bcd, blank, digit_valid, digit_data, digit_idx, done};
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL %s got=%h exp=0", name, obs);
    end
  endtask

  // Raise complete from low; returns just after the capture edge N.
  task automatic start_conv(input logic [15:0] v);
    complete = 1'b0;
    cycle();
    result_in = v;
    complete  = 1'b1;
    model(v);
    cycle();
    total++;
    if (busy !== 1'b1 || bcd_valid !== 1'b0) begin
      bad++;
      $display("FAIL capture busy/valid got=%b%b exp=10", busy, bcd_valid);
    end
  endtask

  // Checks 15-cycle latency and the latched result.
  task automatic wait_result();
    repeat (14) cycle();
    total++;
    if (bcd_valid !== 1'b0) begin
      bad++;
      $display("FAIL early_valid got=%b exp=0", bcd_valid);
    end
    cycle();
    total++;
    if (bcd_valid !== 1'b1 || digit_valid !== 1'b1) begin
      bad++;
      $display("FAIL latency valid got=%b%b exp=11", bcd_valid, digit_valid);
    end
    total++;
    if (bcd !== exp_bcd) begin
      bad++;
      $display("FAIL bcd got=%h exp=%h", bcd, exp_bcd);
    end
    total++;
    if (sign !== exp_sign) begin
      bad++;
      $display("FAIL sign got=%b exp=%b", sign, exp_sign);
    end
    total++;
    if (blank !== exp_blank) begin
      bad++;
      $display("FAIL blank got=%b exp=%b", blank, exp_blank);
    end
  endtask

  // Consume the stream, stalling at stall_idx for stall_len cycles.
  task automatic stream(input int stall_idx, input int stall_len);
    int idx;
    int stalled;
    int budget;
    idx = exp_top;
    stalled = 0;
    budget = 40;
    while (idx >= 0 && budget > 0) begin
      total++;
      if (digit_valid !== 1'b1 || digit_data !== 4'(exp_d[idx]) || digit_idx !== 3'(idx)) begin
        bad++;
        $display("FAIL stream_digit got=%b/%h/%0d exp=1/%h/%0d",
                 digit_valid, digit_data, digit_idx, 4'(exp_d[idx]), idx);
      end
      if (idx == stall_idx && stalled < stall_len) begin
        digit_ready = 1'b0;
        stalled++;
      end else begin
        digit_ready = 1'b1;
      end
      cycle();
      budget--;
      if (digit_ready) begin
        if (idx == 0) begin
          total++;
          if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse got=%b busy=%b exp=1 busy=0", done, busy);
          end
        end
        idx--;
      end
    end
    if (budget == 0) begin
      total++;
      bad++;
      $display("FAIL stream_timeout got=idx%0d exp=finished", idx);
    end
    digit_ready = 1'b1;
    cycle();
    total++;
    if (done !== 1'b0 || bcd_valid !== 1'b1) begin
      bad++;
      $display("FAIL done_width got=%b valid=%b exp=0 valid=1", done, bcd_valid);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    #12;
    check_all_zero("reset_state");
    @(negedge clk);
    nRST = 1'b1;
    cycle();
    check_all_zero("after_reset_idle");
  endtask

  task automatic test_directed();
    start_conv(16'h0022); wait_result(); stream(-1, 0);
    start_conv(16'h8028); wait_result(); stream(-1, 0);
    start_conv(16'h7FFF); wait_result(); stream(2, 3);
    start_conv(16'h8000); wait_result(); stream(-1, 0);
    start_conv(16'h0000); wait_result(); stream(0, 2);
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int n = 0; n < 16; n++) begin
      v = 16'($urandom);
      if (n % 4 == 1) v[14:0] = 15'($urandom_range(0, 99));
      start_conv(v);
      wait_result();
      stream(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_hold_complete();
    int dones;
    dones = 0;
    start_conv(16'h1234);
    for (int c = 1; c < 60; c++) begin
      if (c == 5) complete = 1'b0;
      if (c == 6) complete = 1'b1;
      if (c == 40) complete = 1'b0;
      cycle();
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL hold_done_count got=%0d exp=1", dones);
    end
    total++;
    if (bcd !== exp_bcd || busy !== 1'b0) begin
      bad++;
      $display("FAIL hold_result got=%h busy=%b exp=%h busy=0", bcd, busy, exp_bcd);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    start_conv(16'h0457);
    repeat (6) cycle();
    #2;
    nRST = 1'b0;
    #1;
    check_all_zero("reset_mid_conv");
    complete = 1'b0;
    repeat (3) begin
      cycle();
      if (done === 1'b1) dones++;
    end
    @(negedge clk);
    nRST = 1'b1;
    repeat (20) begin
      cycle();
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_done got=%0d busy=%b exp=0 busy=0", dones, busy);
    end
    start_conv(16'h8457); wait_result(); stream(-1, 0);
    // Reset during STREAM as well.
    start_conv(16'h0321); wait_result();
    digit_ready = 1'b0;
    cycle();
    nRST = 1'b0;
    #1;
    check_all_zero("reset_mid_stream");
    @(negedge clk);
    nRST = 1'b1;
    digit_ready = 1'b1;
    start_conv(16'h0321); wait_result(); stream(-1, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold_complete();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
